interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 31 +++
 rtl/interrupt_controller.sv | 120 ++++++++++++
 tb/tb_interrupt_controller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: flag/enable inputs
// and PC redirect outputs toward the control unit.
interface interrupt_controller_if;
  logic [7:0]  tifr;
  logic [7:0]  timsk;
  logic [1:0]  int_pins;
  logic [1:0]  int_en;
  logic        sreg_i;
  logic        instr_boundary;
  logic        reti;
  logic        pc_overwrite;
  logic [13:0] pc_new;
  logic        sreg_i_clear;
  logic [7:0]  tifr_clear;
  logic [1:0]  intf;
  logic        irq_active;

  modport master (
    output tifr, timsk, int_pins, int_en,
    output sreg_i, instr_boundary, reti,
    input  pc_overwrite, pc_new, sreg_i_clear,
    input  tifr_clear, intf, irq_active
  );

  modport slave (
    input  tifr, timsk, int_pins, int_en,
    input  sreg_i, instr_boundary, reti,
    output pc_overwrite, pc_new, sreg_i_clear,
    output tifr_clear, intf, irq_active
  );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority vectored interrupt controller with
// external pin synchronisers and RETI holdoff.
module interrupt_controller #(
  parameter logic [13:0] VECTOR_BASE = 14'h0000
) (
  input logic clk,
  input logic reset_n,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, DISPATCH, SERVICE, HOLDOFF
  } state_e;

  state_e state_q, state_d;

  logic [1:0]  s1_q, s2_q, s3_q;
  logic [1:0]  rise;
  logic [1:0]  intf_q, intf_d;
  logic [9:0]  pend;
  logic        take;
  logic [13:0] off_d;
  logic [7:0]  tclr_d;
  logic [1:0]  iclr_d;
  logic        ovw_q;
  logic [13:0] pc_q;
  logic [7:0]  tclr_q;
  logic [1:0]  iclr_q;
  logic        act_q;

  assign rise = s2_q & ~s3_q;
  // a fresh edge wins over the dispatch clear
  assign intf_d = (intf_q & ~iclr_q) | rise;

  assign pend = {
    intf_q[0] & bus.int_en[0],
    intf_q[1] & bus.int_en[1],
    bus.tifr & bus.timsk
  };

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      intf_q <= '0;
    end else begin
      s1_q   <= bus.int_pins;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      intf_q <= intf_d;
    end
  end

  always_comb begin
    off_d  = '0;
    tclr_d = '0;
    iclr_d = '0;
    priority case (1'b1)
      pend[9]: begin off_d = 14'h002; iclr_d = 2'b01; end
      pend[8]: begin off_d = 14'h004; iclr_d = 2'b10; end
      pend[7]: begin off_d = 14'h008; tclr_d = 8'h80; end
      pend[6]: begin off_d = 14'h00A; tclr_d = 8'h40; end
      pend[5]: begin off_d = 14'h00C; tclr_d = 8'h20; end
      pend[4]: begin off_d = 14'h00E; tclr_d = 8'h10; end
      pend[3]: begin off_d = 14'h010; tclr_d = 8'h08; end
      pend[2]: begin off_d = 14'h012; tclr_d = 8'h04; end
      pend[1]: begin off_d = 14'h014; tclr_d = 8'h02; end
      pend[0]: begin off_d = 14'h016; tclr_d = 8'h01; end
      default: begin off_d = '0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.instr_boundary && bus.sreg_i && |pend) begin
          take    = 1'b1;
          state_d = DISPATCH;
        end
      end
      DISPATCH: state_d = SERVICE;
      SERVICE: if (bus.reti) state_d = HOLDOFF;
      HOLDOFF: if (bus.instr_boundary) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // winner latched here stays frozen through DISPATCH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovw_q  <= 1'b0;
      pc_q   <= '0;
      tclr_q <= '0;
      iclr_q <= '0;
      act_q  <= 1'b0;
    end else begin
      ovw_q  <= take;
      pc_q   <= take ? VECTOR_BASE + off_d : '0;
      tclr_q <= take ? tclr_d : '0;
      iclr_q <= take ? iclr_d : '0;
      act_q  <= (state_d == DISPATCH) ||
                (state_d == SERVICE);
    end
  end

  assign bus.pc_overwrite = ovw_q;
  assign bus.pc_new       = pc_q;
  assign bus.sreg_i_clear = ovw_q;
  assign bus.tifr_clear   = tclr_q;
  assign bus.intf         = intf_q;
  assign bus.irq_active   = act_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: vector table, directed corner
// sequences and a randomized run against a model.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;

  interrupt_controller_if bus();

  interrupt_controller #(
    .VECTOR_BASE(14'h0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tifr;
    logic [7:0]  timsk;
    logic        sreg;
    logic        ovw;
    logic [13:0] pc;
    logic [7:0]  tclr;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.tifr = '0;
    bus.timsk = '0;
    bus.int_pins = '0;
    bus.int_en = '0;
    bus.sreg_i = 1'b0;
    bus.instr_boundary = 1'b0;
    bus.reti = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    idle_in();
    reset_n = 1'b0;
    tick();
    tick();
    if (check) begin
      chk("rst_ovw", bus.pc_overwrite, 0);
      chk("rst_pc", bus.pc_new, 0);
      chk("rst_tclr", bus.tifr_clear, 0);
      chk("rst_intf", bus.intf, 0);
      chk("rst_irq", bus.irq_active, 0);
    end
    reset_n = 1'b1;
  endtask

  // reference model state
  logic [1:0] hist[4];
  bit m_pulse, m_isr, m_gap;
  logic [1:0] m_intf, m_iclr;
  int offs[10] = '{2, 4, 8, 10, 12, 14, 16, 18, 20, 22};

  function automatic bit m_pending(input int s);
    if (s < 2) return m_intf[s] & bus.int_en[s];
    return bus.tifr[9-s] & bus.timsk[9-s];
  endfunction

  initial begin
    tbl[0] = '{8'h01, 8'h01, 1'b1, 1'b1, 14'h016, 8'h01};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 14'h008, 8'h80};
    tbl[2] = '{8'h11, 8'hFF, 1'b1, 1'b1, 14'h00E, 8'h10};
    tbl[3] = '{8'h11, 8'hEF, 1'b1, 1'b1, 14'h016, 8'h01};
    tbl[4] = '{8'h04, 8'h04, 1'b0, 1'b0, 14'h000, 8'h00};
    tbl[5] = '{8'hFF, 8'h00, 1'b1, 1'b0, 14'h000, 8'h00};
    tbl[6] = '{8'h0C, 8'h0C, 1'b1, 1'b1, 14'h010, 8'h08};
    tbl[7] = '{8'h60, 8'hFF, 1'b1, 1'b1, 14'h00A, 8'h40};
    tbl[8] = '{8'h20, 8'h20, 1'b1, 1'b1, 14'h00C, 8'h20};
    tbl[9] = '{8'h02, 8'h03, 1'b1, 1'b1, 14'h014, 8'h02};

    do_reset(1'b1);

    for (int i = 0; i < 10; i++) begin
      do_reset(1'b0);
      bus.tifr = tbl[i].tifr;
      bus.timsk = tbl[i].timsk;
      bus.sreg_i = tbl[i].sreg;
      bus.instr_boundary = 1'b1;
      tick();
      bus.instr_boundary = 1'b0;
      chk($sformatf("v%0d_ovw", i), bus.pc_overwrite, tbl[i].ovw);
      chk($sformatf("v%0d_pc", i), bus.pc_new, tbl[i].pc);
      chk($sformatf("v%0d_tclr", i), bus.tifr_clear, tbl[i].tclr);
      chk($sformatf("v%0d_sclr", i), bus.sreg_i_clear, tbl[i].ovw);
      chk($sformatf("v%0d_irq", i), bus.irq_active, tbl[i].ovw);
      tick();
      chk($sformatf("v%0d_1cyc", i), bus.pc_overwrite, 0);
    end

    // INT0 beats OCF1A, then OCF1A after RETI gap
    do_reset(1'b0);
    bus.tifr = 8'h11;
    bus.timsk = 8'hFF;
    bus.int_en = 2'b01;
    bus.sreg_i = 1'b1;
    bus.int_pins = 2'b01;
    tick();
    tick();
    chk("s35_early", bus.intf, 2'b00);
    tick();
    chk("s35_intf", bus.intf, 2'b01);
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    chk("s35_pc0", bus.pc_new, 14'h002);
    chk("s35_tclr0", bus.tifr_clear, 8'h00);
    tick();
    chk("s35_iclr", bus.intf, 2'b00);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    chk("s35_irq", bus.irq_active, 0);
    bus.instr_boundary = 1'b1;
    tick();
    chk("s35_hold", bus.pc_overwrite, 0);
    tick();
    bus.instr_boundary = 1'b0;
    chk("s35_pc1", bus.pc_new, 14'h00E);
    chk("s35_tclr1", bus.tifr_clear, 8'h10);

    // masked by sreg_i, then released
    begin
      int n = 0;
      do_reset(1'b0);
      bus.tifr = 8'h04;
      bus.timsk = 8'h04;
      bus.instr_boundary = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        n += int'(bus.pc_overwrite);
      end
      chk("s36_none", n, 0);
      bus.sreg_i = 1'b1;
      tick();
      bus.instr_boundary = 1'b0;
      chk("s36_pc", bus.pc_new, 14'h012);
    end

    // no nesting in SERVICE, one-instruction gap
    do_reset(1'b0);
    bus.tifr = 8'h01;
    bus.timsk = 8'h01;
    bus.sreg_i = 1'b1;
    bus.instr_boundary = 1'b1;
    tick();
    chk("s37_d0", bus.pc_new, 14'h016);
    tick();
    tick();
    tick();
    chk("s37_svc", bus.pc_overwrite, 0);
    chk("s37_act", bus.irq_active, 1);
    bus.instr_boundary = 1'b0;
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    bus.instr_boundary = 1'b1;
    tick();
    chk("s37_gap", bus.pc_overwrite, 0);
    tick();
    bus.instr_boundary = 1'b0;
    chk("s37_d1", bus.pc_new, 14'h016);

    // reset during DISPATCH
    do_reset(1'b0);
    bus.int_en = 2'b01;
    bus.sreg_i = 1'b1;
    bus.int_pins = 2'b01;
    tick();
    tick();
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    chk("s38_disp", bus.pc_overwrite, 1);
    reset_n = 1'b0;
    #1;
    chk("s38_ovw", bus.pc_overwrite, 0);
    tick();
    chk("s38_irq", bus.irq_active, 0);
    chk("s38_intf", bus.intf, 2'b00);
    bus.int_pins = 2'b00;
    bus.instr_boundary = 1'b0;
    reset_n = 1'b1;

    // INT1 flag without enable, then enabled
    do_reset(1'b0);
    bus.sreg_i = 1'b1;
    bus.int_pins = 2'b10;
    tick();
    tick();
    tick();
    chk("s39_intf", bus.intf, 2'b10);
    bus.instr_boundary = 1'b1;
    tick();
    chk("s39_none", bus.pc_overwrite, 0);
    bus.int_en = 2'b10;
    tick();
    bus.instr_boundary = 1'b0;
    chk("s39_pc", bus.pc_new, 14'h004);
    tick();
    chk("s39_clr", bus.intf, 2'b00);

    // new INT0 edge lands on the clearing edge
    do_reset(1'b0);
    bus.int_en = 2'b01;
    bus.sreg_i = 1'b1;
    bus.int_pins = 2'b01;
    tick();
    tick();
    tick();
    bus.int_pins = 2'b00;
    tick();
    bus.int_pins = 2'b01;
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    chk("race_pc", bus.pc_new, 14'h002);
    tick();
    chk("race_keep", bus.intf, 2'b01);

    // randomized run against the reference model
    do_reset(1'b0);
    for (int j = 0; j < 4; j++) hist[j] = '0;
    m_pulse = 0;
    m_isr = 0;
    m_gap = 0;
    m_intf = '0;
    m_iclr = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] edg;
      logic e_ovw;
      logic [13:0] e_pc;
      logic [7:0] e_tclr;
      if (c % 50 == 0) begin
        bus.timsk = 8'($urandom);
        bus.int_en = 2'($urandom);
      end
      if ($urandom_range(7) == 0)
        bus.int_pins[0] = ~bus.int_pins[0];
      if ($urandom_range(7) == 0)
        bus.int_pins[1] = ~bus.int_pins[1];
      if ($urandom_range(15) == 0) begin
        int b = int'($urandom_range(7));
        bus.tifr[b] = 1'b1;
      end
      bus.sreg_i = ($urandom_range(7) != 0);
      bus.instr_boundary = ($urandom_range(2) == 0);
      bus.reti = !m_gap && ($urandom_range(5) == 0);

      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = bus.int_pins;
      edg = hist[2] & ~hist[3];
      e_ovw = 1'b0;
      e_pc = '0;
      e_tclr = '0;
      if (m_pulse) begin
        m_pulse = 0;
        m_isr = 1;
        m_intf = m_intf & ~m_iclr;
        m_iclr = '0;
      end else if (m_isr) begin
        if (bus.reti) begin
          m_isr = 0;
          m_gap = 1;
        end
      end else if (m_gap) begin
        if (bus.instr_boundary) m_gap = 0;
      end else if (bus.instr_boundary && bus.sreg_i) begin
        for (int s = 0; s < 10; s++) begin
          if (!e_ovw && m_pending(s)) begin
            e_ovw = 1'b1;
            e_pc = 14'(offs[s]);
            if (s < 2) m_iclr = 2'(1 << s);
            else e_tclr = 8'h80 >> (s - 2);
          end
        end
        m_pulse = e_ovw;
      end
      m_intf = m_intf | edg;

      tick();
      chk($sformatf("rand%0d", c),
          {5'd0, bus.pc_overwrite, bus.sreg_i_clear,
           bus.pc_new, bus.tifr_clear, bus.intf,
           bus.irq_active},
          {5'd0, e_ovw, e_ovw, e_pc, e_tclr, m_intf,
           m_pulse | m_isr});
      bus.tifr = bus.tifr & ~e_tclr;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
